// File: rtl/time_set_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// time_set_ctrl_pkg
// Shared definitions for the time-set controller and related clock-control
// blocks: FSM state encoding (2 bits), set-target encoding and the default
// hold-delay parameters.
// -----------------------------------------------------------------------------
package time_set_ctrl_pkg;

    // Set-operation FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,  // no set operation in progress
        ST_ARM      = 2'd1,  // first step issued, counting slow strobes before repeat
        ST_REPEAT   = 2'd2,  // auto-repeat at slow or fast rate
        ST_WAIT_REL = 2'd3   // target released with other button held; wait for both low
    } state_e;

    // Which counter the current set operation drives
    typedef enum logic {
        TGT_HRS = 1'b0,
        TGT_MIN = 1'b1
    } target_e;

    // Slow-set strobes a button must stay held after a press before auto-repeat
    localparam int HOLD_DELAY_DEF = 2;
    // Width of the hold-delay counter; HOLD_DELAY must be < 2**CNT_W
    localparam int CNT_W_DEF      = 4;

endpackage : time_set_ctrl_pkg

// File: rtl/time_set_ctrl_press_detect.sv
// -----------------------------------------------------------------------------
// press_detect
// Rising-edge detector for one debounced button level. The history register
// resets to 1, so a button already held when reset releases yields no press
// until it has been released and pressed again.
// Ports:
//   clk    in  1  system clock
//   reset  in  1  synchronous, active-high reset
//   level  in  1  debounced button level
//   press  out 1  high for the cycle in which level rises against its history
// -----------------------------------------------------------------------------
module press_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic press
);

    logic hist_r;

    // Button history register; preset to "held" so reset never creates a press
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_r <= 1'b1;
        end else begin
            hist_r <= level;
        end
    end

    assign press = level & ~hist_r;

endmodule : press_detect

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// Turns debounced set-button levels into single-cycle increment strobes for the
// hours/minutes counters: one immediate step per press, then auto-repeat while
// the button is held, at the slow or fast set rate from clk_gen. All outputs
// are registered (pulse appears one cycle after the qualifying input cycle).
// Parameters:
//   HOLD_DELAY  slow-set strobes held after a press before auto-repeat starts
//   CNT_W       hold counter width; HOLD_DELAY must be < 2**CNT_W
// Ports:
//   i_clk              in  1  system clock
//   i_reset            in  1  synchronous, active-high reset
//   i_slow_set_stb     in  1  slow auto-repeat strobe
//   i_fast_set_stb     in  1  fast auto-repeat strobe
//   i_fast_set_db      in  1  debounced fast-set level; selects fast repeat rate
//   i_set_hours_db     in  1  debounced set-hours level
//   i_set_minutes_db   in  1  debounced set-minutes level
//   o_inc_hours_stb    out 1  increment hours pulse
//   o_inc_minutes_stb  out 1  increment minutes pulse
//   o_clr_seconds_stb  out 1  zero-seconds pulse (first minutes step only)
//   o_setting          out 1  high while a set operation is in progress
// -----------------------------------------------------------------------------
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int HOLD_DELAY = HOLD_DELAY_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_slow_set_stb,
    input  logic i_fast_set_stb,
    input  logic i_fast_set_db,
    input  logic i_set_hours_db,
    input  logic i_set_minutes_db,
    output logic o_inc_hours_stb,
    output logic o_inc_minutes_stb,
    output logic o_clr_seconds_stb,
    output logic o_setting
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_DELAY);

    // Saturating increment of the hold counter; never wraps past HOLD_LIM
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value >= HOLD_LIM) begin
            result = HOLD_LIM;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    state_e           state_r, state_s;
    target_e          target_r, target_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             hrs_press_s, min_press_s;
    logic             tgt_level_s, oth_level_s, rate_stb_s;
    logic             inc_hours_s, inc_minutes_s, clr_seconds_s;

    press_detect u_hours_press (
        .clk   (i_clk),
        .reset (i_reset),
        .level (i_set_hours_db),
        .press (hrs_press_s)
    );

    press_detect u_minutes_press (
        .clk   (i_clk),
        .reset (i_reset),
        .level (i_set_minutes_db),
        .press (min_press_s)
    );

    // Levels of the latched target button and of the other set button, plus the repeat-rate strobe
    always_comb begin
        if (target_r == TGT_MIN) begin
            tgt_level_s = i_set_minutes_db;
            oth_level_s = i_set_hours_db;
        end else begin
            tgt_level_s = i_set_hours_db;
            oth_level_s = i_set_minutes_db;
        end
        rate_stb_s = i_fast_set_db ? i_fast_set_stb : i_slow_set_stb;
    end

    // Next-state, hold-counter and pulse decode for the set FSM
    always_comb begin
        state_s       = state_r;
        target_s      = target_r;
        cnt_s         = cnt_r;
        inc_hours_s   = 1'b0;
        inc_minutes_s = 1'b0;
        clr_seconds_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                // Minutes wins when both buttons rise in the same cycle
                if (min_press_s) begin
                    target_s      = TGT_MIN;
                    inc_minutes_s = 1'b1;
                    clr_seconds_s = 1'b1;
                    state_s       = ST_ARM;
                end else if (hrs_press_s) begin
                    target_s    = TGT_HRS;
                    inc_hours_s = 1'b1;
                    state_s     = ST_ARM;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ARM: begin
                if (!tgt_level_s) begin
                    cnt_s   = '0;
                    state_s = oth_level_s ? ST_WAIT_REL : ST_IDLE;
                end else if (i_slow_set_stb) begin
                    // The HOLD_DELAY-th strobe only arms repeat; it does not pulse
                    cnt_s = sat_inc(cnt_r);
                    if (cnt_s >= HOLD_LIM) begin
                        state_s = ST_REPEAT;
                    end else begin
                        state_s = ST_ARM;
                    end
                end else begin
                    state_s = ST_ARM;
                end
            end

            ST_REPEAT: begin
                if (!tgt_level_s) begin
                    cnt_s   = '0;
                    state_s = oth_level_s ? ST_WAIT_REL : ST_IDLE;
                end else if (rate_stb_s) begin
                    // Repeats never re-clear seconds
                    if (target_r == TGT_MIN) begin
                        inc_minutes_s = 1'b1;
                    end else begin
                        inc_hours_s = 1'b1;
                    end
                end else begin
                    state_s = ST_REPEAT;
                end
            end

            ST_WAIT_REL: begin
                cnt_s = '0;
                if (!i_set_hours_db && !i_set_minutes_db) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_REL;
                end
            end

            default: begin
                cnt_s   = '0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, target, hold counter and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r           <= ST_IDLE;
            target_r          <= TGT_HRS;
            cnt_r             <= '0;
            o_inc_hours_stb   <= 1'b0;
            o_inc_minutes_stb <= 1'b0;
            o_clr_seconds_stb <= 1'b0;
            o_setting         <= 1'b0;
        end else begin
            state_r           <= state_s;
            target_r          <= target_s;
            cnt_r             <= cnt_s;
            o_inc_hours_stb   <= inc_hours_s;
            o_inc_minutes_stb <= inc_minutes_s;
            o_clr_seconds_stb <= clr_seconds_s;
            o_setting         <= (state_s != ST_IDLE);
        end
    end

endmodule : time_set_ctrl

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
// Directed self-checking bench for time_set_ctrl. Inputs change 1 ns after a
// rising edge; outputs are sampled at the same point, so each sample shows the
// registered response to the inputs of the cycle just clocked.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

    logic clk = 1'b0;
    logic i_reset = 1'b1;
    logic i_slow_set_stb = 1'b0;
    logic i_fast_set_stb = 1'b0;
    logic i_fast_set_db = 1'b0;
    logic i_set_hours_db = 1'b0;
    logic i_set_minutes_db = 1'b0;
    logic o_inc_hours_stb, o_inc_minutes_stb, o_clr_seconds_stb, o_setting;

    int checks = 0;
    int failures = 0;
    int n_h, n_m, n_c;

    always #5 clk = ~clk;

    time_set_ctrl #(.HOLD_DELAY(2), .CNT_W(4)) dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_slow_set_stb    (i_slow_set_stb),
        .i_fast_set_stb    (i_fast_set_stb),
        .i_fast_set_db     (i_fast_set_db),
        .i_set_hours_db    (i_set_hours_db),
        .i_set_minutes_db  (i_set_minutes_db),
        .o_inc_hours_stb   (o_inc_hours_stb),
        .o_inc_minutes_stb (o_inc_minutes_stb),
        .o_clr_seconds_stb (o_clr_seconds_stb),
        .o_setting         (o_setting)
    );

    // One clock with the given strobes, then accumulate pulse counts
    task automatic tick(input logic slow, input logic fast);
        i_slow_set_stb = slow;
        i_fast_set_stb = fast;
        @(posedge clk);
        #1;
        i_slow_set_stb = 1'b0;
        i_fast_set_stb = 1'b0;
        n_h += int'(o_inc_hours_stb);
        n_m += int'(o_inc_minutes_stb);
        n_c += int'(o_clr_seconds_stb);
    endtask

    function automatic logic [3:0] outs();
        return {o_inc_hours_stb, o_inc_minutes_stb, o_clr_seconds_stb, o_setting};
    endfunction

    task automatic clear_counts();
        n_h = 0; n_m = 0; n_c = 0;
    endtask

    task automatic test_reset();
        i_set_hours_db = 1'b1;
        i_reset = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        checks++;
        if (outs() !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000", outs());
        end
        i_reset = 1'b0;
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b1);
        end
        checks++;
        if (n_h !== 0 || o_setting !== 1'b0) begin
            failures++;
            $display("FAIL held_through_reset hours=%0d setting=%b exp=0,0", n_h, o_setting);
        end
        i_set_hours_db = 1'b0;
        tick(1'b0, 1'b0);
        i_set_hours_db = 1'b1;
        tick(1'b0, 1'b0);
        checks++;
        if (outs() !== 4'b1001) begin
            failures++;
            $display("FAIL repress_hours got=%b exp=1001", outs());
        end
        tick(1'b0, 1'b0);
        checks++;
        if (outs() !== 4'b0001) begin
            failures++;
            $display("FAIL repress_single got=%b exp=0001", outs());
        end
        i_set_hours_db = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_minutes_short();
        clear_counts();
        i_set_minutes_db = 1'b1;
        tick(1'b1, 1'b0);   // strobe with the press is not counted
        checks++;
        if (outs() !== 4'b0111) begin
            failures++;
            $display("FAIL min_press got=%b exp=0111", outs());
        end
        tick(1'b1, 1'b0);   // first counted strobe
        tick(1'b0, 1'b0);
        checks++;
        if (outs() !== 4'b0001) begin
            failures++;
            $display("FAIL min_arm_hold got=%b exp=0001", outs());
        end
        i_set_minutes_db = 1'b0;
        tick(1'b1, 1'b0);   // release cycle: strobe ignored
        checks++;
        if (outs() !== 4'b0000) begin
            failures++;
            $display("FAIL min_release got=%b exp=0000", outs());
        end
        tick(1'b0, 1'b0);
        checks++;
        if (n_m !== 1 || n_c !== 1 || n_h !== 0) begin
            failures++;
            $display("FAIL min_short_counts got h=%0d m=%0d c=%0d exp 0,1,1", n_h, n_m, n_c);
        end
    endtask

    task automatic test_hours_repeat();
        int bad;
        bad = 0;
        clear_counts();
        i_set_hours_db = 1'b1;
        tick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0);
            if (o_inc_hours_stb !== (i >= 2)) bad++;
            tick(1'b0, 1'b1);   // fast strobe ignored while fast_set low
            if (o_inc_hours_stb !== 1'b0) bad++;
            tick(1'b0, 1'b0);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL hours_repeat_timing bad_samples=%0d exp=0", bad);
        end
        checks++;
        if (n_h !== 9 || n_m !== 0 || n_c !== 0) begin
            failures++;
            $display("FAIL hours_repeat_counts got h=%0d m=%0d c=%0d exp 9,0,0", n_h, n_m, n_c);
        end
        i_set_hours_db = 1'b0;
        tick(1'b0, 1'b0);
        checks++;
        if (o_setting !== 1'b0) begin
            failures++;
            $display("FAIL hours_release_setting got=%b exp=0", o_setting);
        end
    endtask

    task automatic test_fast_switch();
        clear_counts();
        i_set_minutes_db = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);   // enters repeat, no pulse
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end
        checks++;
        if (n_m !== 4 || n_c !== 1) begin
            failures++;
            $display("FAIL min_slow_repeat got m=%0d c=%0d exp 4,1", n_m, n_c);
        end
        i_fast_set_db = 1'b1;
        tick(1'b1, 1'b0);
        checks++;
        if (outs() !== 4'b0001) begin
            failures++;
            $display("FAIL fast_ignores_slow got=%b exp=0001", outs());
        end
        tick(1'b0, 1'b1);
        checks++;
        if (outs() !== 4'b0101) begin
            failures++;
            $display("FAIL fast_pulse got=%b exp=0101", outs());
        end
        tick(1'b1, 1'b1);
        checks++;
        if (outs() !== 4'b0101) begin
            failures++;
            $display("FAIL coincident_pulse got=%b exp=0101", outs());
        end
        tick(1'b0, 1'b0);
        checks++;
        if (n_m !== 6 || n_c !== 1 || n_h !== 0) begin
            failures++;
            $display("FAIL fast_counts got h=%0d m=%0d c=%0d exp 0,6,1", n_h, n_m, n_c);
        end
        i_fast_set_db = 1'b0;
        i_set_minutes_db = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_both_press();
        clear_counts();
        i_set_hours_db = 1'b1;
        i_set_minutes_db = 1'b1;
        tick(1'b0, 1'b0);
        checks++;
        if (outs() !== 4'b0111) begin
            failures++;
            $display("FAIL both_press got=%b exp=0111", outs());
        end
        i_set_minutes_db = 1'b0;
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b1);
        end
        checks++;
        if (o_setting !== 1'b1 || n_h !== 0 || n_m !== 1) begin
            failures++;
            $display("FAIL wait_rel got setting=%b h=%0d m=%0d exp 1,0,1", o_setting, n_h, n_m);
        end
        i_set_hours_db = 1'b0;
        tick(1'b0, 1'b0);
        checks++;
        if (o_setting !== 1'b0) begin
            failures++;
            $display("FAIL wait_rel_exit got=%b exp=0", o_setting);
        end
        i_set_hours_db = 1'b1;
        tick(1'b0, 1'b0);
        checks++;
        if (outs() !== 4'b1001) begin
            failures++;
            $display("FAIL hours_after_wait got=%b exp=1001", outs());
        end
        i_set_hours_db = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        i_set_hours_db = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        checks++;
        if (outs() !== 4'b1001) begin
            failures++;
            $display("FAIL pre_reset_repeat got=%b exp=1001", outs());
        end
        i_reset = 1'b1;
        tick(1'b1, 1'b0);
        checks++;
        if (outs() !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b exp=0000", outs());
        end
        i_reset = 1'b0;
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end
        checks++;
        if (n_h !== 0 || o_setting !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_held got h=%0d setting=%b exp 0,0", n_h, o_setting);
        end
        i_set_hours_db = 1'b0;
        tick(1'b0, 1'b0);
    endtask

    task automatic test_fast_alone();
        clear_counts();
        i_fast_set_db = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1);
            tick(1'b0, 1'b1);
        end
        checks++;
        if (n_h !== 0 || n_m !== 0 || n_c !== 0 || o_setting !== 1'b0) begin
            failures++;
            $display("FAIL fast_alone got h=%0d m=%0d c=%0d setting=%b exp all 0",
                     n_h, n_m, n_c, o_setting);
        end
        i_fast_set_db = 1'b0;
        tick(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_minutes_short();
        test_hours_repeat();
        test_fast_switch();
        test_both_press();
        test_reset_mid();
        test_fast_alone();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_time_set_ctrl
